calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-low; a 0 sampled at a rising clock edge resets the block.
REQ-003 The block SHALL have the port key_code, input, 5 bits: 0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 clear; values 16-31 are ignored.
REQ-004 The block SHALL have the port key_press, input, 1 bit: one-cycle strobe qualifying key_code.
REQ-005 The block SHALL have the port operand_a, output, 5 bits: first operand; 5'b11111 means empty.
REQ-006 The block SHALL have the port operand_b, output, 5 bits: second operand; 5'b11111 means empty.
REQ-007 The block SHALL have the port op_sel, output, 2 bits: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 The block SHALL have the ports a_loaded and b_loaded, outputs, 1 bit each: operand A / operand B holds a valid digit.
REQ-009 The block SHALL have the port result, output, 8 bits: signed two's-complement result.
REQ-010 The block SHALL have the ports result_valid, busy and error, outputs, 1 bit each.
REQ-011 The block SHALL have the port state, output, 3 bits: WAIT_A=0, WAIT_B=1, EXEC=2, DONE=3, ERROR=4.

Function
REQ-012 Key acceptance: a key SHALL be accepted only on an edge with key_press=1.
- Clear is accepted in every state.
- All other keys SHALL be ignored while busy=1.
REQ-013 Clear SHALL have exactly the reset effect (REQ-024) on the same edge.
REQ-014 WAIT_A:
- Digit: load operand_a and set a_loaded=1; a later digit overwrites it.
- Operator with a_loaded=1: load op_sel and go to WAIT_B.
- Operator with a_loaded=0: ignored.
- Equals: ignored.
REQ-015 WAIT_B:
- Digit: load operand_b and set b_loaded=1 (overwrite allowed).
- Operator: replace op_sel.
- Equals with b_loaded=1: go to EXEC and set busy=1.
- Equals with b_loaded=0: ignored.
REQ-016 EXEC entry at edge N: load remainder=A and quotient=0.
- add/sub/mul: write result at edge N+1.
- div: at each edge while remainder>=B, subtract B and increment quotient; write result=quotient on the first edge where remainder<B, i.e. edge N+1+q.
- Maximum latency is 10 cycles (9/1).
REQ-017 On the result-write edge, the block SHALL go to DONE with result_valid=1 and busy=0.
REQ-018 Arithmetic rules:
- Operands are zero-extended to 8 bits.
- sub = A-B, signed (range -9..9).
- mul range is 0..81.
- div is the truncated quotient.
- Overflow is impossible.
REQ-019 Divide by zero (op_sel=11, B=0): the edge entering EXEC detects it; at edge N+1 the block SHALL go to ERROR with error=1, result=0, busy=0.
REQ-020 DONE:
- Digit: load operand_a with the digit, a_loaded=1, operand_b=5'b11111, b_loaded=0, result_valid=0, go to WAIT_A.
- Operator or equals: ignored.
- result holds until then.
REQ-021 ERROR: all keys except clear SHALL be ignored; error stays 1.
REQ-022 Clear during EXEC SHALL abort the computation without writing result.
REQ-023 Reset SHALL dominate key_press on the same edge.

Reset
REQ-024 On reset, the block SHALL set: state=WAIT_A, operand_a=operand_b=5'b11111, a_loaded=b_loaded=0, op_sel=00, result=0, result_valid=0, busy=0, error=0, internal remainder/quotient=0.
REQ-025 There SHALL be no asynchronous behaviour; outputs are registered and change only at clock edges.

Verification
REQ-026 Scenario (add): keys 7, add, 5, equals (one per cycle) -> busy=1 for one cycle; result=12, result_valid=1, state=DONE one edge after equals.
REQ-027 Scenario (sub): keys 3, sub, 8, equals -> result=8'hFB (-5).
REQ-028 Scenario (div, latency): keys 9, div, 1, equals -> busy=1 for 10 cycles, result=9; keys 7, div, 2 -> result=3 after 4 cycles.
REQ-029 Scenario (divide by zero): keys 4, div, 0, equals -> state=ERROR, error=1, result=0; digit 5 is ignored; clear returns to WAIT_A with operand_a=5'b11111.
REQ-030 Scenario (ignored keys): add before any digit is ignored; equals in WAIT_B with b_loaded=0 is ignored; keys pressed during div EXEC are ignored except clear, which aborts with result_valid=0.
REQ-031 Scenario (reset and restart): reset low for one edge mid-entry -> all REQ-024 values; digit in DONE starts a new entry with operand_b cleared.

Source files
------------

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer
// Purpose  : Key-driven single-digit calculator sequencer. It collects
//            operand A, an operator and operand B from a keypad strobe, then
//            computes add/sub/mul in one cycle or divide by repeated
//            subtraction, and reports the signed 8-bit result.
// Ports    : clock        - single clock, rising edge
//            reset        - synchronous, active-low
//            key_code     - 0-9 digit, 10 add, 11 sub, 12 mul, 13 div,
//                           14 equals, 15 clear, 16-31 ignored
//            key_press    - one-cycle strobe qualifying key_code
//            operand_a/b  - stored operands, 5'b11111 when empty
//            op_sel       - 00 add, 01 sub, 10 mul, 11 div
//            a_loaded/b_loaded - operand holds a valid digit
//            result       - signed two's-complement result
//            result_valid, busy, error - status flags
//            state        - WAIT_A=0, WAIT_B=1, EXEC=2, DONE=3, ERROR=4
// Revision : 1.0 - initial release
// ============================================================================
module calc_sequencer (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] key_code,
   input  logic       key_press,
   output logic [4:0] operand_a,
   output logic [4:0] operand_b,
   output logic [1:0] op_sel,
   output logic       a_loaded,
   output logic       b_loaded,
   output logic [7:0] result,
   output logic       result_valid,
   output logic       busy,
   output logic       error,
   output logic [2:0] state
);

   localparam logic [2:0] ST_WAIT_A = 3'd0;
   localparam logic [2:0] ST_WAIT_B = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_DONE   = 3'd3;
   localparam logic [2:0] ST_ERROR  = 3'd4;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [4:0] EMPTY      = 5'b11111;
   localparam logic [4:0] KEY_ADD    = 5'd10;
   localparam logic [4:0] KEY_DIV    = 5'd13;
   localparam logic [4:0] KEY_EQUALS = 5'd14;
   localparam logic [4:0] KEY_CLEAR  = 5'd15;

   // Divide iteration registers; operands never exceed 9 so 4 bits suffice.
   logic [3:0] remainder;
   logic [3:0] quotient;

   logic       key_clear;
   logic       key_digit;
   logic       key_oper;
   logic       key_equals;
   logic [1:0] key_op_sel;
   logic [7:0] a_ext;
   logic [7:0] b_ext;
   logic [7:0] alu_result;
   logic       div_zero;
   logic       div_finished;

   assign key_clear  = key_press && (key_code == KEY_CLEAR);
   assign key_digit  = key_press && (key_code < KEY_ADD);
   assign key_oper   = key_press && (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
   assign key_equals = key_press && (key_code == KEY_EQUALS);

   // Operator keys 10..13 have low bits 10,11,00,01; flipping bit 1 maps
   // them onto the op_sel encoding 00,01,10,11.
   assign key_op_sel = {~key_code[1], key_code[0]};

   assign a_ext = {3'b000, operand_a};
   assign b_ext = {3'b000, operand_b};

   // Operands are stable throughout EXEC because non-clear keys are ignored
   // while busy, so the zero-divisor test can look at them directly.
   assign div_zero     = (op_sel == OP_DIV) && (operand_b == 5'd0);
   assign div_finished = (remainder < operand_b[3:0]);

   always_comb begin
      alu_result = 8'd0;
      case (op_sel)
         OP_ADD:  alu_result = a_ext + b_ext;
         OP_SUB:  alu_result = a_ext - b_ext;
         OP_MUL:  alu_result = a_ext * b_ext;
         default: alu_result = {4'b0000, quotient};
      endcase
   end

   always_ff @(posedge clock) begin
      // Clear has exactly the reset effect, so both share one branch.
      if (!reset || key_clear) begin
         state        <= ST_WAIT_A;
         operand_a    <= EMPTY;
         operand_b    <= EMPTY;
         a_loaded     <= 1'b0;
         b_loaded     <= 1'b0;
         op_sel       <= OP_ADD;
         result       <= 8'd0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         error        <= 1'b0;
         remainder    <= 4'd0;
         quotient     <= 4'd0;
      end else begin
         case (state)
            ST_WAIT_A: begin
               if (key_digit) begin
                  operand_a <= key_code;
                  a_loaded  <= 1'b1;
               end else if (key_oper && a_loaded) begin
                  op_sel <= key_op_sel;
                  state  <= ST_WAIT_B;
               end
            end

            ST_WAIT_B: begin
               if (key_digit) begin
                  operand_b <= key_code;
                  b_loaded  <= 1'b1;
               end else if (key_oper) begin
                  op_sel <= key_op_sel;
               end else if (key_equals && b_loaded) begin
                  state     <= ST_EXEC;
                  busy      <= 1'b1;
                  remainder <= operand_a[3:0];
                  quotient  <= 4'd0;
               end
            end

            ST_EXEC: begin
               if (div_zero) begin
                  state  <= ST_ERROR;
                  error  <= 1'b1;
                  result <= 8'd0;
                  busy   <= 1'b0;
               end else if ((op_sel != OP_DIV) || div_finished) begin
                  state        <= ST_DONE;
                  result       <= alu_result;
                  result_valid <= 1'b1;
                  busy         <= 1'b0;
               end else begin
                  remainder <= remainder - operand_b[3:0];
                  quotient  <= quotient + 4'd1;
               end
            end

            ST_DONE: begin
               // A digit starts a fresh entry; result is left as it was.
               if (key_digit) begin
                  operand_a    <= key_code;
                  a_loaded     <= 1'b1;
                  operand_b    <= EMPTY;
                  b_loaded     <= 1'b0;
                  result_valid <= 1'b0;
                  state        <= ST_WAIT_A;
               end
            end

            ST_ERROR: begin
               // Only clear (handled above) leaves this state.
            end

            default: state <= ST_WAIT_A;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_sequencer
// Purpose  : Self-checking bench for calc_sequencer: a vector table, hand
//            sequences for divide latency / divide-by-zero / abort, and a
//            randomized run compared against a behavioural calculator model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] key_code = 5'd0;
   logic       key_press = 1'b0;
   logic [4:0] operand_a;
   logic [4:0] operand_b;
   logic [1:0] op_sel;
   logic       a_loaded;
   logic       b_loaded;
   logic [7:0] result;
   logic       result_valid;
   logic       busy;
   logic       error;
   logic [2:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   calc_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .key_code     (key_code),
      .key_press    (key_press),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .op_sel       (op_sel),
      .a_loaded     (a_loaded),
      .b_loaded     (b_loaded),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy),
      .error        (error),
      .state        (state)
   );

   always #5 clock = ~clock;

   // ------------------------------------------------------------------
   // Behavioural model: tracks the calculator at the level of "what the
   // user has entered" and a countdown to when the answer appears.
   // ------------------------------------------------------------------
   int         m_state;
   int         m_a, m_b, m_op;
   bit         m_al, m_bl, m_rv, m_busy, m_err, m_res_known, m_dz;
   logic [7:0] m_res, m_pend;
   int         m_left;

   task automatic model_reset();
      m_state = 0; m_a = 31; m_b = 31; m_op = 0;
      m_al = 0; m_bl = 0; m_rv = 0; m_busy = 0; m_err = 0;
      m_res = 8'd0; m_res_known = 1; m_dz = 0; m_left = 0; m_pend = 8'd0;
   endtask

   task automatic model_step(bit rst_n, bit press, int code);
      int v;
      if (!rst_n || (press && code == 15)) begin
         model_reset();
         return;
      end
      case (m_state)
         0: if (press) begin
               if (code < 10) begin m_a = code; m_al = 1; end
               else if (code >= 10 && code <= 13 && m_al) begin
                  m_op = code - 10; m_state = 1;
               end
            end
         1: if (press) begin
               if (code < 10) begin m_b = code; m_bl = 1; end
               else if (code >= 10 && code <= 13) m_op = code - 10;
               else if (code == 14 && m_bl) begin
                  m_state = 2; m_busy = 1; m_dz = 0; m_left = 1; v = 0;
                  case (m_op)
                     0: v = m_a + m_b;
                     1: v = m_a - m_b;
                     2: v = m_a * m_b;
                     default: begin
                        if (m_b == 0) m_dz = 1;
                        else begin v = m_a / m_b; m_left = m_a / m_b + 1; end
                     end
                  endcase
                  m_pend = 8'(v);
               end
            end
         2: begin
               m_left--;
               if (m_left == 0) begin
                  m_busy = 0;
                  if (m_dz) begin m_state = 4; m_err = 1; m_res = 8'd0; end
                  else begin m_state = 3; m_res = m_pend; m_rv = 1; end
               end
            end
         3: if (press && code < 10) begin
               m_a = code; m_al = 1; m_b = 31; m_bl = 0; m_rv = 0;
               m_state = 0; m_res_known = 0;
            end
         default: ;
      endcase
   endtask

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_compare();
      check("m_state", int'(state), m_state);
      check("m_operand_a", int'(operand_a), m_a);
      check("m_operand_b", int'(operand_b), m_b);
      check("m_op_sel", int'(op_sel), m_op);
      check("m_a_loaded", int'(a_loaded), int'(m_al));
      check("m_b_loaded", int'(b_loaded), int'(m_bl));
      if (m_res_known) check("m_result", int'(result), int'(m_res));
      check("m_result_valid", int'(result_valid), int'(m_rv));
      check("m_busy", int'(busy), int'(m_busy));
      check("m_error", int'(error), int'(m_err));
   endtask

   // Drive one cycle: inputs set away from the edge, model advanced on the
   // edge, outputs compared 1 time unit later.
   task automatic tick(bit rst_n, bit press, int code);
      reset     = rst_n;
      key_press = press;
      key_code  = 5'(code);
      @(posedge clock);
      model_step(rst_n, press, code);
      #1;
      model_compare();
   endtask

   task automatic count_busy(string name, int exp_cycles, int exp_res);
      int cnt = 0;
      int guard = 0;
      if (busy) cnt = 1;
      while (busy && guard < 30) begin
         tick(1, 0, 0);
         if (busy) cnt++;
         guard++;
      end
      if (guard >= 30) $display("FAIL %s_timeout: busy still %0d, expected 0", name, busy);
      check({name, "_busy_cycles"}, cnt, exp_cycles);
      check({name, "_result"}, int'(result), exp_res);
      check({name, "_state"}, int'(state), 3);
   endtask

   typedef struct {
      bit rst_n; bit press; int code;
      int st; int a; int res; bit chk_res; bit rv; bit busy; bit err;
   } vec_t;

   vec_t vt[23];

   initial begin
      int r, code;
      bit rst_n, press;

      vt[0]  = '{0,0,0,  0,31,0,  1,0,0,0};   // reset state
      vt[1]  = '{1,1,7,  0,7, 0,  1,0,0,0};
      vt[2]  = '{1,1,10, 1,7, 0,  1,0,0,0};
      vt[3]  = '{1,1,5,  1,7, 0,  1,0,0,0};
      vt[4]  = '{1,1,14, 2,7, 0,  1,0,1,0};   // busy for one cycle
      vt[5]  = '{1,0,0,  3,7, 12, 1,1,0,0};   // 7+5
      vt[6]  = '{1,1,3,  0,3, 0,  0,0,0,0};   // digit in DONE
      vt[7]  = '{1,1,11, 1,3, 0,  0,0,0,0};
      vt[8]  = '{1,1,8,  1,3, 0,  0,0,0,0};
      vt[9]  = '{1,1,14, 2,3, 0,  0,0,1,0};
      vt[10] = '{1,0,0,  3,3, 251,1,1,0,0};   // 3-8 = -5
      vt[11] = '{1,1,20, 3,3, 251,1,1,0,0};   // out-of-range code ignored
      vt[12] = '{1,1,10, 3,3, 251,1,1,0,0};   // operator in DONE ignored
      vt[13] = '{1,1,15, 0,31,0,  1,0,0,0};   // clear
      vt[14] = '{1,1,10, 0,31,0,  1,0,0,0};   // operator without A ignored
      vt[15] = '{1,1,2,  0,2, 0,  1,0,0,0};
      vt[16] = '{1,1,12, 1,2, 0,  1,0,0,0};
      vt[17] = '{1,1,14, 1,2, 0,  1,0,0,0};   // equals without B ignored
      vt[18] = '{1,1,9,  1,2, 0,  1,0,0,0};
      vt[19] = '{1,1,14, 2,2, 0,  1,0,1,0};
      vt[20] = '{1,0,0,  3,2, 18, 1,1,0,0};   // 2*9
      vt[21] = '{1,1,4,  0,4, 0,  0,0,0,0};
      vt[22] = '{0,1,5,  0,31,0,  1,0,0,0};   // reset beats key press

      model_reset();

      for (int i = 0; i < 23; i++) begin
         tick(vt[i].rst_n, vt[i].press, vt[i].code);
         check($sformatf("vec%0d_state", i), int'(state), vt[i].st);
         check($sformatf("vec%0d_operand_a", i), int'(operand_a), vt[i].a);
         if (vt[i].chk_res) check($sformatf("vec%0d_result", i), int'(result), vt[i].res);
         check($sformatf("vec%0d_result_valid", i), int'(result_valid), int'(vt[i].rv));
         check($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].busy));
         check($sformatf("vec%0d_error", i), int'(error), int'(vt[i].err));
      end

      // Divide 9/1: longest computation.
      tick(1,1,9); tick(1,1,13); tick(1,1,1); tick(1,1,14);
      count_busy("div9_1", 10, 9);

      // Divide 7/2 starting from DONE.
      tick(1,1,7); tick(1,1,13); tick(1,1,2); tick(1,1,14);
      count_busy("div7_2", 4, 3);

      // Divide by zero.
      tick(1,1,15); tick(1,1,4); tick(1,1,13); tick(1,1,0); tick(1,1,14);
      check("dz_exec_state", int'(state), 2);
      tick(1,0,0);
      check("dz_state", int'(state), 4);
      check("dz_error", int'(error), 1);
      check("dz_result", int'(result), 0);
      check("dz_busy", int'(busy), 0);
      tick(1,1,5);
      check("dz_digit_ignored_state", int'(state), 4);
      check("dz_digit_ignored_a", int'(operand_a), 4);
      tick(1,1,15);
      check("dz_clear_state", int'(state), 0);
      check("dz_clear_a", int'(operand_a), 31);
      check("dz_clear_error", int'(error), 0);

      // Keys during divide are ignored; clear aborts.
      tick(1,1,9); tick(1,1,13); tick(1,1,1); tick(1,1,14);
      tick(1,1,3); tick(1,1,10);
      check("abort_busy", int'(busy), 1);
      check("abort_state", int'(state), 2);
      check("abort_operand_b", int'(operand_b), 1);
      check("abort_op_sel", int'(op_sel), 3);
      tick(1,1,15);
      check("abort_clear_state", int'(state), 0);
      check("abort_clear_busy", int'(busy), 0);
      for (int i = 0; i < 12; i++) tick(1,0,0);
      check("abort_no_result_valid", int'(result_valid), 0);
      check("abort_no_result", int'(result), 0);

      // Randomized run against the model.
      tick(0,0,0);
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom % 150) != 0;
         press = ($urandom % 4) != 0;
         r = $urandom % 20;
         if (r == 0)      code = 15;
         else if (r == 1) code = 16 + int'($urandom % 16);
         else             code = int'($urandom % 15);
         tick(rst_n, press, code);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
